// File: rtl/seven_seg_scanner.sv
// Time-multiplexed driver for an 8-digit common-anode 7-segment display.
// Each digit slot is a BLANK gap (all anodes off) followed by a DRIVE phase.
// Inputs are snapshotted once per frame so a frame never shows mixed data.
module seven_seg_scanner #(
  parameter int unsigned DIGIT_CYCLES = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [31:0] digits,
  input  logic [7:0]  dp,
  input  logic [7:0]  digit_en,
  output logic [6:0]  SEG,
  output logic        DP,
  output logic [7:0]  AN,
  output logic        frame_done
);

  localparam int unsigned MAX_CYC = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DIGIT_CYCLES - 1);

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             restart_q;
  logic             take_snap;

  logic [31:0]      snap_dig_q, snap_dig_d;
  logic [7:0]       snap_dp_q, snap_dp_d;
  logic [7:0]       snap_en_q, snap_en_d;

  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             frame_done_q, frame_done_d;

  logic [3:0]       cur_nibble;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Next-state, snapshot capture and next output values.
  // restart_q marks the first edge after reset: that edge is treated as the
  // entry into BLANK for idx 0, so it takes the snapshot and starts cnt at 0.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q + CNT_W'(1);
    take_snap    = 1'b0;
    frame_done_d = 1'b0;

    if (restart_q) begin
      state_d   = BLANK;
      idx_d     = 3'd0;
      cnt_d     = '0;
      take_snap = 1'b1;
    end else begin
      case (state_q)
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = DRIVE;
            cnt_d   = '0;
          end
        end
        DRIVE: begin
          if (cnt_q == DRIVE_LAST) begin
            state_d = BLANK;
            cnt_d   = '0;
            idx_d   = idx_q + 3'd1;
            if (idx_q == 3'd7) begin
              frame_done_d = 1'b1;
              take_snap    = 1'b1;
            end
          end
        end
        default: begin
          state_d = BLANK;
          cnt_d   = '0;
        end
      endcase
    end

    snap_dig_d = snap_dig_q;
    snap_dp_d  = snap_dp_q;
    snap_en_d  = snap_en_q;
    if (take_snap) begin
      snap_dig_d = digits;
      snap_dp_d  = dp;
      snap_en_d  = digit_en;
    end

    // Entering DRIVE never coincides with a snapshot, so snap_*_q is current here.
    cur_nibble = snap_dig_q[{idx_d, 2'b00} +: 4];
    an_d  = '1;
    seg_d = '1;
    dp_d  = 1'b1;
    if (state_d == DRIVE && snap_en_q[idx_d]) begin
      an_d  = ~(8'd1 << idx_d);
      seg_d = hex7(cur_nibble);
      dp_d  = ~snap_dp_q[idx_d];
    end
  end

  // Scan FSM with registered outputs and per-frame snapshot.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q      <= BLANK;
      idx_q        <= '0;
      cnt_q        <= '0;
      restart_q    <= 1'b1;
      snap_dig_q   <= '0;
      snap_dp_q    <= '0;
      snap_en_q    <= '0;
      an_q         <= '1;
      seg_q        <= '1;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      restart_q    <= 1'b0;
      snap_dig_q   <= snap_dig_d;
      snap_dp_q    <= snap_dp_d;
      snap_en_q    <= snap_en_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign AN         = an_q;
  assign SEG        = seg_q;
  assign DP         = dp_q;
  assign frame_done = frame_done_q;

endmodule
